// File: rtl/timed_memory_responder_pkg.sv
// Shared types and widths for the timed memory responder.
package timed_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_resp_state_t;

    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = 8;

endpackage

// File: rtl/timed_memory_responder_if.sv
// CPU-side memory bus: request fields from the CPU, completion/data back from memory.
interface timed_memory_responder_if;
    import timed_memory_responder_pkg::*;

    logic              read;
    logic              write;
    logic [MASK_W-1:0] wmask;
    logic [31:0]       address;
    logic [DATA_W-1:0] wdata;
    logic              resp;
    logic [DATA_W-1:0] rdata;
    logic              proto_err;

    modport master (
        output read, write, wmask, address, wdata,
        input  resp, rdata, proto_err
    );

    modport slave (
        input  read, write, wmask, address, wdata,
        output resp, rdata, proto_err
    );

endinterface

// File: rtl/timed_memory_responder_ram.sv
// byte_mask_ram: synchronous single-port-style RAM with a registered read port and
// a byte-masked write port; storage is never cleared, only the read register resets.
module byte_mask_ram
    import timed_memory_responder_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [MASK_W-1:0] wr_mask_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (wr_mask_i[b]) begin
                    mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Read register holds its value between reads so rdata stays stable on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/timed_memory_responder.sv
// Single-outstanding-request memory with fixed programmable latency.
// Optional protocol checker enabled by defining MEM_PROTOCOL_CHECK_EN.
module timed_memory_responder
    import timed_memory_responder_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    timed_memory_responder_if.slave  mem_bus
);

    mem_resp_state_t   state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              resp_q;

    logic              op_wr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic              req;
    logic              accept;
    logic [ADDR_W-1:0] addr_idx;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              wr_en_d;

    assign req      = mem_bus.read | mem_bus.write;
    assign accept   = (state_q == IDLE) && req;
    assign addr_idx = mem_bus.address[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (req) begin
                        cnt_q <= CNT_W'(LATENCY - 1);
                        if (LATENCY > 1) begin
                            state_q <= BUSY;
                        end else begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                        end
                    end
                end
                // cnt reaches zero on the edge that enters RESP, so resp lands LATENCY cycles after acceptance.
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_wr_q <= mem_bus.write;
            idx_q   <= addr_idx;
            wdata_q <= mem_bus.wdata;
            wmask_q <= mem_bus.wmask;
        end
    end

    // With LATENCY==1 the read is launched straight from the live bus address.
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = idx_q;
        if (state_q == IDLE) begin
            rd_addr_d = addr_idx;
            rd_en_d   = (LATENCY == 1) && req && !mem_bus.write;
        end else if (state_q == BUSY) begin
            rd_en_d   = (cnt_q == CNT_W'(1)) && !op_wr_q;
        end
    end

    assign wr_en_d = (state_q == RESP) && op_wr_q && !rst;

    byte_mask_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (rd_en_d),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (mem_bus.rdata),
        .wr_en_i   (wr_en_d),
        .wr_addr_i (idx_q),
        .wr_mask_i (wmask_q),
        .wr_data_i (wdata_q)
    );

    assign mem_bus.resp = resp_q;

`ifdef MEM_PROTOCOL_CHECK_EN
    logic        rd_req_q;
    logic        wr_req_q;
    logic [31:0] addr_full_q;
    logic        proto_err_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_req_q    <= mem_bus.read;
            wr_req_q    <= mem_bus.write;
            addr_full_q <= mem_bus.address;
        end
    end

    // Sticky: any request field moving while BUSY, or read+write together at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (accept && mem_bus.read && mem_bus.write) begin
            proto_err_q <= 1'b1;
        end else if ((state_q == BUSY) &&
                     ((mem_bus.read    != rd_req_q)    ||
                      (mem_bus.write   != wr_req_q)    ||
                      (mem_bus.address != addr_full_q) ||
                      (mem_bus.wdata   != wdata_q)     ||
                      (mem_bus.wmask   != wmask_q))) begin
            proto_err_q <= 1'b1;
        end
    end

    assign mem_bus.proto_err = proto_err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_bus.address[31:ADDR_W+2], mem_bus.address[1:0]};

    assign mem_bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_timed_memory_responder.sv
// Scoreboard bench: two responders (LATENCY 4 and 1) driven by directed requests.
module tb_timed_memory_responder;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef MEM_PROTOCOL_CHECK_EN
    localparam logic PE_EXP = 1'b1;
`else
    localparam logic PE_EXP = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timed_memory_responder_if b4 ();
    timed_memory_responder_if b1 ();

    timed_memory_responder #(.ADDR_W(14), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .mem_bus(b4)
    );
    timed_memory_responder #(.ADDR_W(14), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_bus(b1)
    );

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        q4[$];
    exp_t        q1[$];
    logic [31:0] last4 = 32'h0;
    logic [31:0] last1 = 32'h0;
    bit          prev4 = 1'b0;
    bit          prev1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a responder pulses resp.
    always @(negedge clk) begin
        exp_t e;
        if (b4.resp === 1'b1) begin
            check("resp4_width", {31'b0, prev4}, 32'h0);
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp4_unexpected: resp at cycle %0d with no request pending", cyc);
            end else begin
                e = q4.pop_front();
                check("resp4_cycle", cyc, e.cyc);
                check("rdata4", b4.rdata, e.rdata);
            end
        end
        prev4 = (b4.resp === 1'b1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (b1.resp === 1'b1) begin
            check("resp1_width", {31'b0, prev1}, 32'h0);
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp1_unexpected: resp at cycle %0d with no request pending", cyc);
            end else begin
                e = q1.pop_front();
                check("resp1_cycle", cyc, e.cyc);
                check("rdata1", b1.rdata, e.rdata);
            end
        end
        prev1 = (b1.resp === 1'b1);
    end

    task automatic drive(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m);
        if (d == 0) begin
            b4.read = rd; b4.write = wr; b4.address = a; b4.wdata = wd; b4.wmask = m;
        end else begin
            b1.read = rd; b1.write = wr; b1.address = a; b1.wdata = wd; b1.wmask = m;
        end
    endtask

    task automatic wait_resp(input int d, output int rc);
        bit seen = 1'b0;
        rc = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if ((d == 0 && b4.resp === 1'b1) || (d == 1 && b1.resp === 1'b1)) begin
                seen = 1'b1;
                rc   = cyc;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: dut%0d gave no resp within 300 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input int d, input int lat, input logic wr, input logic [31:0] exp_rd);
        exp_t e;
        e.cyc = cyc + lat;
        if (wr) begin
            e.rdata = (d == 0) ? last4 : last1;
        end else begin
            e.rdata = exp_rd;
            if (d == 0) last4 = exp_rd; else last1 = exp_rd;
        end
        if (d == 0) q4.push_back(e); else q1.push_back(e);
    endtask

    task automatic issue(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m, input logic [31:0] exp_rd,
                         output int rc);
        expect_push(d, (d == 0) ? 4 : 1, wr, exp_rd);
        drive(d, rd, wr, a, wd, m);
        wait_resp(d, rc);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int rc, rc1, rc2, rc3, t0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp4", {31'b0, b4.resp}, 32'h0);
        check("reset_rdata4", b4.rdata, 32'h0);
        check("reset_perr4", {31'b0, b4.proto_err}, 32'h0);
        check("reset_resp1", {31'b0, b1.resp}, 32'h0);
        check("reset_rdata1", b1.rdata, 32'h0);
        rst = 1'b0;

        // Preload, read back, byte-masked write, zero-mask write.
        issue(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, rc);
        issue(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, rc);
        issue(0, 1'b0, 1'b1, 32'h200, 32'hAABBCCDD, 4'hF, 32'h0, rc);
        issue(0, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'b0101, 32'h0, rc);
        issue(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'hAA22CC44, rc);
        issue(0, 1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 4'b0000, 32'h0, rc);
        issue(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'hAA22CC44, rc);

        // Back-to-back read, write, read.
        t0 = cyc;
        issue(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, rc1);
        issue(0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, rc2);
        issue(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 32'hCAFEF00D, rc3);
        check("b2b_resp1", rc1 - t0, 32'd4);
        check("b2b_resp2", rc2 - t0, 32'd9);
        check("b2b_resp3", rc3 - t0, 32'd14);

        // Reset two cycles into a write: discarded, no resp.
        issue(0, 1'b0, 1'b1, 32'h300, 32'h13572468, 4'hF, 32'h0, rc);
        drive(0, 1'b0, 1'b1, 32'h300, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_resp", {31'b0, b4.resp}, 32'h0);
        check("rst_mid_rdata", b4.rdata, 32'h0);
        check("rst_mid_perr", {31'b0, b4.proto_err}, 32'h0);
        last4 = 32'h0;
        last1 = 32'h0;
        repeat (6) @(posedge clk);
        #1;
        issue(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h13572468, rc);

        // Address changed mid-BUSY: data still from the original address.
        expect_push(0, 4, 1'b0, 32'hDEADBEEF);
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        wait_resp(0, rc);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("perr_set", {31'b0, b4.proto_err}, {31'b0, PE_EXP});
        repeat (3) @(posedge clk);
        #1;
        check("perr_sticky", {31'b0, b4.proto_err}, {31'b0, PE_EXP});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("perr_cleared", {31'b0, b4.proto_err}, 32'h0);
        last4 = 32'h0;
        last1 = 32'h0;

        // LATENCY=1: aliasing and read+write treated as write.
        issue(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, rc);
        issue(1, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'h12345678, rc);
        issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, rc);
        issue(1, 1'b1, 1'b1, 32'h500, 32'h0BADCAFE, 4'hF, 32'h0, rc);
        issue(1, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 32'h0BADCAFE, rc);
        issue(1, 1'b0, 1'b1, 32'h500, 32'h77000000, 4'b1000, 32'h0, rc);
        issue(1, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 32'h77ADCAFE, rc);

        repeat (4) @(posedge clk);
        #1;
        check("q4_drained", q4.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
